// File: rtl/beat_timer.sv
// Metronome timebase: a sequential restoring divider turns BPM and subdivision
// into a sub-beat period; a down-counter emits aligned sub-beat, beat and bar pulses.
module beat_timer #(
  parameter int unsigned FREQ        = 24000000,
  parameter int unsigned BPM_MIN     = 30,
  parameter int unsigned BPM_MAX     = 300,
  parameter int unsigned BPM_DEFAULT = 120,
  parameter int unsigned SUBDIV_MAX  = 8,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [8:0]       bpm,
  input  logic [3:0]       subdiv,
  input  logic             bpm_load,
  input  logic [3:0]       beats_per_bar,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic             sub_tick,
  output logic             beat_tick,
  output logic             bar_tick,
  output logic [3:0]       beat_index
);

  localparam int unsigned DIVIDEND = FREQ * 60;
  localparam int DIV_W = $clog2(DIVIDEND + 1);
  localparam int DVS_W = 13;
  localparam int BC_W  = $clog2(DIV_W + 1);
  localparam logic [DIV_W-1:0] DVD_INIT   = DIV_W'(DIVIDEND);
  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DIVIDEND / BPM_DEFAULT);
  localparam logic [8:0]       BPM_LO     = 9'(BPM_MIN);
  localparam logic [8:0]       BPM_HI     = 9'(BPM_MAX);
  localparam logic [3:0]       SUB_HI     = 4'(SUBDIV_MAX);
  localparam logic [BC_W-1:0]  BC_INIT    = BC_W'(DIV_W);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [DIV_W-1:0]  rem_q, rem_d, dvd_q, dvd_d, quo_q, quo_d;
  logic [DVS_W-1:0]  dvs_q, dvs_d;
  logic [3:0]        lsub_q, lsub_d;
  logic [CNT_W-1:0]  pend_per_q, pend_per_d;
  logic [3:0]        pend_sub_q, pend_sub_d;
  logic              pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]  period_q, period_d, cnt_q, cnt_d;
  logic [3:0]        asub_q, asub_d, sidx_q, sidx_d, bidx_q, bidx_d;
  logic              started_q, started_d, busy_q, busy_d;
  logic              sub_tick_q, sub_tick_d, beat_tick_q, beat_tick_d, bar_tick_q, bar_tick_d;

  logic [8:0]        bpm_c;
  logic [3:0]        sub_c, bpb_eff, sub_use;
  logic [DVS_W-1:0]  divisor;
  logic [DIV_W:0]    trial;
  logic              fits;
  logic [CNT_W-1:0]  per_use;
  logic [4:0]        beat_nxt;

  always_comb begin
    bpm_c = bpm;
    if (bpm < BPM_LO)      bpm_c = BPM_LO;
    else if (bpm > BPM_HI) bpm_c = BPM_HI;
    sub_c = subdiv;
    if (subdiv == 4'd0)        sub_c = 4'd1;
    else if (subdiv > SUB_HI)  sub_c = SUB_HI;
    divisor = DVS_W'(bpm_c) * DVS_W'(sub_c);
    bpb_eff = (beats_per_bar == 4'd0) ? 4'd1 : beats_per_bar;
    trial   = {rem_q, dvd_q[DIV_W-1]};
    fits    = trial >= (DIV_W+1)'(dvs_q);
  end

  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    lsub_d     = lsub_q;
    pend_per_d = pend_per_q;
    pend_sub_d = pend_sub_q;
    pend_vld_d = pend_vld_q;
    period_d   = period_q;
    asub_d     = asub_q;
    cnt_d      = cnt_q;
    sidx_d     = sidx_q;
    bidx_d     = bidx_q;
    started_d  = started_q;
    sub_tick_d  = 1'b0;
    beat_tick_d = 1'b0;
    bar_tick_d  = 1'b0;
    per_use    = period_q;
    sub_use    = asub_q;
    beat_nxt   = 5'd0;

    if (!enable) begin
      cnt_d     = '0;
      sidx_d    = 4'd0;
      bidx_d    = 4'd0;
      started_d = 1'b0;
      if (pend_vld_q) begin
        period_d   = pend_per_q;
        asub_d     = pend_sub_q;
        pend_vld_d = 1'b0;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      // New tempo only lands on a beat boundary so the current beat keeps its length.
      if (sidx_q == 4'd0 && pend_vld_q) begin
        per_use    = pend_per_q;
        sub_use    = pend_sub_q;
        period_d   = pend_per_q;
        asub_d     = pend_sub_q;
        pend_vld_d = 1'b0;
      end
      cnt_d      = per_use - CNT_W'(1);
      sub_tick_d = 1'b1;
      if (sidx_q == 4'd0) begin
        // beat_index advances as the next beat starts, so it names the beat being ticked.
        beat_nxt = {1'b0, bidx_q} + 5'd1;
        if (!started_q || beat_nxt >= {1'b0, bpb_eff}) beat_nxt = 5'd0;
        beat_tick_d = 1'b1;
        bar_tick_d  = (beat_nxt == 5'd0);
        bidx_d      = beat_nxt[3:0];
        started_d   = 1'b1;
      end
      sidx_d = ({1'b0, sidx_q} + 5'd1 >= {1'b0, sub_use}) ? 4'd0 : sidx_q + 4'd1;
    end

    case (state_q)
      S_DIV: begin
        rem_d = fits ? DIV_W'(trial - (DIV_W+1)'(dvs_q)) : DIV_W'(trial);
        quo_d = {quo_q[DIV_W-2:0], fits};
        dvd_d = dvd_q << 1;
        bc_d  = bc_q - BC_W'(1);
        if (bc_q == BC_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        pend_per_d = CNT_W'(quo_q);
        pend_sub_d = lsub_q;
        pend_vld_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: ;
    endcase

    if (bpm_load) begin
      state_d = S_DIV;
      bc_d    = BC_INIT;
      rem_d   = '0;
      dvd_d   = DVD_INIT;
      quo_d   = '0;
      dvs_d   = divisor;
      lsub_d  = sub_c;
    end
    busy_d = (state_d == S_DIV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bc_q        <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      lsub_q      <= 4'd1;
      pend_per_q  <= '0;
      pend_sub_q  <= 4'd1;
      pend_vld_q  <= 1'b0;
      period_q    <= PERIOD_RST;
      asub_q      <= 4'd1;
      cnt_q       <= '0;
      sidx_q      <= 4'd0;
      bidx_q      <= 4'd0;
      started_q   <= 1'b0;
      busy_q      <= 1'b0;
      sub_tick_q  <= 1'b0;
      beat_tick_q <= 1'b0;
      bar_tick_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bc_q        <= bc_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      lsub_q      <= lsub_d;
      pend_per_q  <= pend_per_d;
      pend_sub_q  <= pend_sub_d;
      pend_vld_q  <= pend_vld_d;
      period_q    <= period_d;
      asub_q      <= asub_d;
      cnt_q       <= cnt_d;
      sidx_q      <= sidx_d;
      bidx_q      <= bidx_d;
      started_q   <= started_d;
      busy_q      <= busy_d;
      sub_tick_q  <= sub_tick_d;
      beat_tick_q <= beat_tick_d;
      bar_tick_q  <= bar_tick_d;
    end
  end

  assign busy       = busy_q;
  assign period     = period_q;
  assign sub_tick   = sub_tick_q;
  assign beat_tick  = beat_tick_q;
  assign bar_tick   = bar_tick_q;
  assign beat_index = bidx_q;

endmodule

// File: tb/tb_beat_timer.sv
// Self-checking bench for beat_timer (FREQ=1000): scoreboarded tick stream and
// divider results, tempo commit at beat boundary, clamps, restart and reset abort.
module tb_beat_timer;
  localparam int FREQ  = 1000;
  localparam int CNT_W = 26;

  logic             clk = 1'b0;
  logic             rst_n, enable, bpm_load;
  logic [8:0]       bpm;
  logic [3:0]       subdiv, beats_per_bar;
  logic             busy, sub_tick, beat_tick, bar_tick;
  logic [CNT_W-1:0] period;
  logic [3:0]       beat_index;

  beat_timer #(.FREQ(FREQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bpm(bpm), .subdiv(subdiv),
    .bpm_load(bpm_load), .beats_per_bar(beats_per_bar), .busy(busy), .period(period),
    .sub_tick(sub_tick), .beat_tick(beat_tick), .bar_tick(bar_tick), .beat_index(beat_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] flags;
    logic [3:0] bidx;
  } tick_t;

  tick_t tick_q[$];
  int    exp_period_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_period(input int b, input int s);
    int bc, sc;
    bc = (b < 30) ? 30 : ((b > 300) ? 300 : b);
    sc = (s == 0) ? 1 : ((s > 8) ? 8 : s);
    return (FREQ * 60) / (bc * sc);
  endfunction

  task automatic push_tick(input int c, input bit beat, input bit bar, input int bidx);
    tick_t e;
    e.cyc   = c;
    e.flags = {1'b1, beat, bar};
    e.bidx  = 4'(bidx);
    tick_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_load(input int b, input int s);
    bpm      = 9'(b);
    subdiv   = 4'(s);
    bpm_load = 1'b1;
    @(negedge clk);
    bpm_load = 1'b0;
    check_eq("busy_rise", 32'(busy), 1);
  endtask

  task automatic busy_count(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Tick monitor: every pulse must match the head of the scoreboard.
  tick_t mon_e;
  always @(negedge clk) begin
    if (sub_tick || beat_tick || bar_tick) begin
      $display("tick cyc=%0d sub=%b beat=%b bar=%b idx=%0d", cyc, sub_tick, beat_tick, bar_tick, beat_index);
      if (tick_q.size() == 0) begin
        check_eq("tick_unexp", 32'({sub_tick, beat_tick, bar_tick}), 0);
      end else begin
        mon_e = tick_q.pop_front();
        check_eq("tick_cyc", 32'(cyc), 32'(mon_e.cyc));
        check_eq("tick_flags", 32'({sub_tick, beat_tick, bar_tick}), 32'(mon_e.flags));
        check_eq("tick_bidx", 32'(beat_index), 32'(mon_e.bidx));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, prev, bpb, nb;
    rst_n = 1'b1; enable = 1'b0; bpm_load = 1'b0;
    bpm = 9'd120; subdiv = 4'd1; beats_per_bar = 4'd4;
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ticks", 32'({sub_tick, beat_tick, bar_tick}), 0);
    check_eq("rst_bidx", 32'(beat_index), 0);
    check_eq("rst_period", 32'(period), 500);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Default tempo: ticks together one cycle after enable, then every 500.
    k = cyc;
    enable = 1'b1;
    for (int i = 0; i < 9; i++) push_tick(k + 1 + 500 * i, 1'b1, (i % 4) == 0, i % 4);
    wait_cyc(k + 4011);
    enable = 1'b0;
    check_eq("s1_left", 32'(tick_q.size()), 0);
    check_eq("s1_period", 32'(period), 500);
    @(negedge clk);

    // Reload while running: old spacing holds until the next beat.
    k = cyc;
    enable = 1'b1;
    push_tick(k + 1, 1'b1, 1'b1, 0);
    wait_cyc(k + 100);
    $display("load bpm=120 subdiv=4 while running");
    do_load(120, 4);
    busy_count(n);
    check_eq("s2_busy_len", 32'(n), 16);
    for (int j = 0; j < 13; j++) begin
      nb = (1 + j / 4) % 4;
      push_tick(k + 501 + 125 * j, (j % 4) == 0, ((j % 4) == 0) && nb == 0, nb);
    end
    wait_cyc(k + 501 + 1500 + 10);
    enable = 1'b0;
    check_eq("s2_left", 32'(tick_q.size()), 0);
    check_eq("s2_period", 32'(period), 125);
    @(negedge clk);

    // Clamp boundaries while stopped; pending result applies at once.
    begin
      int lb[6] = '{7, 400, 0, 30, 300, 120};
      int ls[6] = '{1, 1, 1, 15, 8, 0};
      for (int i = 0; i < 6; i++) begin
        $display("load bpm=%0d subdiv=%0d", lb[i], ls[i]);
        exp_period_q.push_back(model_period(lb[i], ls[i]));
        do_load(lb[i], ls[i]);
        busy_count(n);
        check_eq("s3_busy_len", 32'(n), 16);
        repeat (2) @(negedge clk);
        check_eq("s3_period", 32'(period), 32'(exp_period_q.pop_front()));
      end
    end

    // Restart: second load three cycles later discards the first.
    $display("load bpm=60 then bpm=240");
    exp_period_q.push_back(model_period(60, 1));
    do_load(60, 1);
    @(negedge clk);
    @(negedge clk);
    void'(exp_period_q.pop_back());
    exp_period_q.push_back(model_period(240, 1));
    do_load(240, 1);
    busy_count(n);
    check_eq("s4_busy_len", 32'(n), 16);
    repeat (2) @(negedge clk);
    check_eq("s4_period", 32'(period), 32'(exp_period_q.pop_front()));
    repeat (30) @(negedge clk);
    check_eq("s4_period_hold", 32'(period), 250);

    // Bar length shrinks under the current beat index.
    beats_per_bar = 4'd4;
    k = cyc;
    enable = 1'b1;
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      bpb = (i < 4) ? 4 : 2;
      nb  = (i == 0) ? 0 : (((prev + 1) >= bpb) ? 0 : prev + 1);
      push_tick(k + 1 + 250 * i, 1'b1, nb == 0, nb);
      prev = nb;
    end
    wait_cyc(k + 800);
    check_eq("s5_bidx3", 32'(beat_index), 3);
    beats_per_bar = 4'd2;
    wait_cyc(k + 1 + 1500 + 10);
    enable = 1'b0;
    check_eq("s5_left", 32'(tick_q.size()), 0);
    beats_per_bar = 4'd4;
    @(negedge clk);

    // Reset mid-division and mid-count.
    k = cyc;
    enable = 1'b1;
    push_tick(k + 1, 1'b1, 1'b1, 0);
    wait_cyc(k + 50);
    do_load(60, 1);
    wait_cyc(k + 56);
    #2 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    $display("reset asserted mid-division");
    check_eq("s6_busy", 32'(busy), 0);
    check_eq("s6_ticks", 32'({sub_tick, beat_tick, bar_tick}), 0);
    check_eq("s6_bidx", 32'(beat_index), 0);
    check_eq("s6_period", 32'(period), 500);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(cyc + 600);
    check_eq("s6_busy_after", 32'(busy), 0);
    check_eq("s6_period_after", 32'(period), 500);
    check_eq("s6_left", 32'(tick_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
